// File: rtl/threefish_input_loader.sv
// rtl/threefish_input_loader.sv - assembles key/tweak/block from a 32-bit word stream and launches the Threefish control
module threefish_input_loader #(
   parameter int WORD_W      = 32,
   parameter int KEY_WORDS   = 16,
   parameter int TWEAK_WORDS = 4,
   parameter int BLOCK_WORDS = 16
) (
   input  logic                            inClk,
   input  logic                            inRstN,
   input  logic [WORD_W-1:0]               inData,
   input  logic                            inValid,
   input  logic [1:0]                      inSel,
   output logic                            outReady,
   input  logic                            inBusy,
   output logic [KEY_WORDS*WORD_W-1:0]     outKey,
   output logic [TWEAK_WORDS*WORD_W-1:0]   outTweak,
   output logic [BLOCK_WORDS*WORD_W-1:0]   outBlock,
   output logic                            outKeyWr,
   output logic                            outTweakWr,
   output logic                            outBlockWr,
   output logic                            outErr
);

   typedef enum logic [1:0] {FILL, LAUNCH, WAIT_HI, WAIT_LO} state_t;

   localparam logic [3:0] KEY_LAST   = 4'(KEY_WORDS - 1);
   localparam logic [1:0] TWEAK_LAST = 2'(TWEAK_WORDS - 1);
   localparam logic [3:0] BLOCK_LAST = 4'(BLOCK_WORDS - 1);

   state_t     state;
   logic [3:0] keyCnt;
   logic [1:0] tweakCnt;
   logic [3:0] blockCnt;
   logic       keyFull;
   logic       tweakFull;
   logic       blockFull;

   logic       accept;
   logic       keyWe;
   logic       tweakWe;
   logic       blockWe;
   logic       errWord;
   logic       allFullNxt;

   // Full flags are looked at one edge early so the edge accepting the last word can also launch.
   always_comb begin
      outReady   = (state == FILL);
      accept     = inValid && outReady;
      keyWe      = accept && (inSel == 2'd0) && !keyFull;
      tweakWe    = accept && (inSel == 2'd1) && !tweakFull;
      blockWe    = accept && (inSel == 2'd2) && !blockFull;
      errWord    = accept && ((inSel == 2'd3) ||
                              ((inSel == 2'd0) && keyFull) ||
                              ((inSel == 2'd1) && tweakFull) ||
                              ((inSel == 2'd2) && blockFull));
      allFullNxt = (keyFull   || (keyWe   && (keyCnt   == KEY_LAST))) &&
                   (tweakFull || (tweakWe && (tweakCnt == TWEAK_LAST))) &&
                   (blockFull || (blockWe && (blockCnt == BLOCK_LAST)));
   end

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         state      <= FILL;
         keyCnt     <= '0;
         tweakCnt   <= '0;
         blockCnt   <= '0;
         keyFull    <= 1'b0;
         tweakFull  <= 1'b0;
         blockFull  <= 1'b0;
         outKey     <= '0;
         outTweak   <= '0;
         outBlock   <= '0;
         outKeyWr   <= 1'b0;
         outTweakWr <= 1'b0;
         outBlockWr <= 1'b0;
         outErr     <= 1'b0;
      end else begin
         if (keyWe) begin
            outKey[{keyCnt, 5'd0} +: WORD_W] <= inData;
            keyCnt <= keyCnt + 4'd1;
            if (keyCnt == KEY_LAST) keyFull <= 1'b1;
         end
         if (tweakWe) begin
            outTweak[{tweakCnt, 5'd0} +: WORD_W] <= inData;
            tweakCnt <= tweakCnt + 2'd1;
            if (tweakCnt == TWEAK_LAST) tweakFull <= 1'b1;
         end
         if (blockWe) begin
            outBlock[{blockCnt, 5'd0} +: WORD_W] <= inData;
            blockCnt <= blockCnt + 4'd1;
            if (blockCnt == BLOCK_LAST) blockFull <= 1'b1;
         end
         if (errWord) outErr <= 1'b1;

         case (state)
            FILL: begin
               if (allFullNxt && !inBusy) begin
                  state      <= LAUNCH;
                  outKeyWr   <= 1'b1;
                  outTweakWr <= 1'b1;
                  outBlockWr <= 1'b1;
               end
            end
            LAUNCH: begin
               state      <= WAIT_HI;
               outKeyWr   <= 1'b0;
               outTweakWr <= 1'b0;
               outBlockWr <= 1'b0;
            end
            // Control raises busy a couple of cycles after the strobe; wait for it before watching the fall.
            WAIT_HI: begin
               if (inBusy) state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!inBusy) begin
                  state     <= FILL;
                  keyCnt    <= '0;
                  tweakCnt  <= '0;
                  blockCnt  <= '0;
                  keyFull   <= 1'b0;
                  tweakFull <= 1'b0;
                  blockFull <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_threefish_input_loader.sv
// tb/tb_threefish_input_loader.sv - directed self-checking bench for threefish_input_loader
module tb_threefish_input_loader;

   logic          inClk = 1'b0;
   logic          inRstN = 1'b0;
   logic [31:0]   inData = '0;
   logic          inValid = 1'b0;
   logic [1:0]    inSel = '0;
   logic          outReady;
   logic          inBusy;
   logic [511:0]  outKey;
   logic [127:0]  outTweak;
   logic [511:0]  outBlock;
   logic          outKeyWr, outTweakWr, outBlockWr, outErr;

   logic forceBusy = 1'b0;
   logic ctrlBusy = 1'b0;
   logic ctrlEn = 1'b0;
   assign inBusy = forceBusy | ctrlBusy;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   int cyc = 0;
   int busyFallCyc = 0;

   logic [31:0] mKey[16];
   logic [31:0] mTweak[4];
   logic [31:0] mBlock[16];
   int mKc, mTc, mBc;
   logic mErr;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] data;
      logic        expReady;
      logic        expWr;
   } vec_t;
   vec_t tbl[36];

   threefish_input_loader dut (
      .inClk(inClk), .inRstN(inRstN), .inData(inData), .inValid(inValid), .inSel(inSel),
      .outReady(outReady), .inBusy(inBusy), .outKey(outKey), .outTweak(outTweak),
      .outBlock(outBlock), .outKeyWr(outKeyWr), .outTweakWr(outTweakWr),
      .outBlockWr(outBlockWr), .outErr(outErr)
   );

   always #5 inClk = ~inClk;
   always @(posedge inClk) cyc++;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Every strobe cycle counts as a pulse; the three strobes must agree.
   always @(negedge inClk) begin
      if (inRstN && (outKeyWr || outTweakWr || outBlockWr)) begin
         pulses++;
         chk("strobes_together", {outKeyWr, outTweakWr, outBlockWr}, 3'b111);
      end
   end

   // Behavioural block control: busy from 2 cycles after the launch cycle, for 73 cycles.
   always @(negedge inClk) begin
      if (ctrlEn && outKeyWr === 1'b1) begin
         @(posedge inClk);
         @(posedge inClk);
         #2 ctrlBusy = 1'b1;
         repeat (73) @(posedge inClk);
         #2 ctrlBusy = 1'b0;
         busyFallCyc = cyc;
      end
   end

   function automatic logic [511:0] packKey();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = mKey[i];
      return r;
   endfunction

   function automatic logic [511:0] packBlock();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = mBlock[i];
      return r;
   endfunction

   function automatic logic [127:0] packTweak();
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = mTweak[i];
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge inClk);
         #1;
      end
   endtask

   task automatic sendWord(input logic [1:0] s, input logic [31:0] d);
      logic rdy;
      inSel = s;
      inData = d;
      inValid = 1'b1;
      rdy = outReady;
      @(posedge inClk);
      #1;
      inValid = 1'b0;
      if (rdy) begin
         if (s == 2'd0 && mKc < 16) begin mKey[mKc] = d; mKc++; end
         else if (s == 2'd1 && mTc < 4) begin mTweak[mTc] = d; mTc++; end
         else if (s == 2'd2 && mBc < 16) begin mBlock[mBc] = d; mBc++; end
         else mErr = 1'b1;
      end
   endtask

   task automatic checkRegs(input string nm);
      chk({nm, "_key"}, outKey, packKey());
      chk({nm, "_tweak"}, {384'd0, outTweak}, {384'd0, packTweak()});
      chk({nm, "_block"}, outBlock, packBlock());
      chk({nm, "_err"}, outErr, mErr);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 16; i++) begin mKey[i] = '0; mBlock[i] = '0; end
      for (int i = 0; i < 4; i++) mTweak[i] = '0;
      mKc = 0; mTc = 0; mBc = 0; mErr = 1'b0;
   endtask

   task automatic doReset();
      inRstN = 1'b0;
      modelReset();
      #3;
      @(negedge inClk);
      inRstN = 1'b1;
      @(posedge inClk);
      #1;
   endtask

   task automatic loadAll(input logic [31:0] kb, input logic [31:0] tb, input logic [31:0] bb);
      for (int i = 0; i < 16; i++) sendWord(2'd0, kb + 32'(i));
      for (int i = 0; i < 4; i++) sendWord(2'd1, tb + 32'(i));
      for (int i = 0; i < 16; i++) sendWord(2'd2, bb + 32'(i));
   endtask

   // Waits for the loader to come back to FILL after a control run.
   task automatic finishRun(input string nm);
      int n;
      n = 0;
      while (outReady !== 1'b1 && n < 300) begin
         idle(1);
         n++;
      end
      chk({nm, "_ready_back"}, outReady, 1'b1);
      chk({nm, "_ready_cycle"}, cyc, busyFallCyc + 1);
      mKc = 0; mTc = 0; mBc = 0;
   endtask

   initial begin
      int kk, tt, bb, p0;
      modelReset();

      // reset state
      #3;
      chk("rst_ready", outReady, 1'b1);
      chk("rst_wr", {outKeyWr, outTweakWr, outBlockWr}, 3'b000);
      chk("rst_err", outErr, 1'b0);
      chk("rst_key", outKey, '0);
      chk("rst_tweak", {384'd0, outTweak}, '0);
      chk("rst_block", outBlock, '0);
      @(negedge inClk);
      inRstN = 1'b1;
      @(posedge inClk);
      #1;

      // sequential load from the vector table, then a full control run
      for (int i = 0; i < 16; i++) tbl[i] = '{2'd0, 32'(i), 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) tbl[16+i] = '{2'd1, 32'hA0 + 32'(i), 1'b1, 1'b0};
      for (int i = 0; i < 16; i++) tbl[20+i] = '{2'd2, 32'hB0 + 32'(i), 1'b1, 1'b0};
      tbl[35].expReady = 1'b0;
      tbl[35].expWr = 1'b1;
      ctrlEn = 1'b1;
      for (int i = 0; i < 36; i++) begin
         sendWord(tbl[i].sel, tbl[i].data);
         chk($sformatf("seq_ready_%0d", i), outReady, tbl[i].expReady);
         chk($sformatf("seq_wr_%0d", i), outBlockWr, tbl[i].expWr);
      end
      chk("seq_key_lo", outKey[31:0], 32'h0);
      chk("seq_key_hi", outKey[511:480], 32'h0F);
      chk("seq_tweak_hi", outTweak[127:96], 32'hA3);
      checkRegs("seq");
      idle(1);
      chk("seq_one_cycle", {outKeyWr, outTweakWr, outBlockWr, outReady}, 4'b0000);
      finishRun("seq");
      chk("seq_pulses", pulses, 1);

      // second load, interleaved with gaps and new data
      kk = 0; tt = 0; bb = 0;
      while (kk < 16 || tt < 4 || bb < 16) begin
         case ($urandom_range(0, 2))
            0: if (kk < 16) begin sendWord(2'd0, 32'h1000 + 32'(kk)); kk++; end
            1: if (tt < 4) begin sendWord(2'd1, 32'h2000 + 32'(tt)); tt++; end
            default: if (bb < 16) begin sendWord(2'd2, 32'h3000 + 32'(bb)); bb++; end
         endcase
         if (kk < 16 || tt < 4 || bb < 16) idle($urandom_range(0, 2));
      end
      chk("mix_wr", outTweakWr, 1'b1);
      checkRegs("mix");
      finishRun("mix");
      chk("mix_pulses", pulses, 2);

      // completion while busy is held high
      ctrlEn = 1'b0;
      forceBusy = 1'b1;
      loadAll(32'h4000, 32'h5000, 32'h6000);
      chk("busy_no_wr", outKeyWr, 1'b0);
      chk("busy_ready", outReady, 1'b1);
      idle(3);
      chk("busy_pulses", pulses, 2);
      sendWord(2'd1, 32'hEEEE_EEEE);
      chk("busy_err", outErr, 1'b1);
      chk("busy_tweak_kept", {384'd0, outTweak}, {384'd0, 128'h00005003_00005002_00005001_00005000});
      checkRegs("busy");
      forceBusy = 1'b0;
      idle(1);
      chk("busy_launch", {outKeyWr, outTweakWr, outBlockWr}, 3'b111);
      idle(1);
      forceBusy = 1'b1;
      idle(2);
      forceBusy = 1'b0;
      idle(1);
      chk("busy_back_fill", outReady, 1'b1);
      chk("busy_pulses_end", pulses, 3);
      mKc = 0; mTc = 0; mBc = 0;

      // reserved target word, then a full run with the sticky error
      doReset();
      chk("rsv_clear_err", outErr, 1'b0);
      sendWord(2'd3, 32'hDEADBEEF);
      chk("rsv_err", outErr, 1'b1);
      chk("rsv_ready", outReady, 1'b1);
      ctrlEn = 1'b1;
      p0 = pulses;
      loadAll(32'h7000, 32'h8000, 32'h9000);
      chk("rsv_launch", outKeyWr, 1'b1);
      checkRegs("rsv");
      finishRun("rsv");
      chk("rsv_err_sticky", outErr, 1'b1);
      chk("rsv_pulses", pulses, p0 + 1);
      ctrlEn = 1'b0;

      // reset mid-load after 7 key words
      doReset();
      for (int i = 0; i < 7; i++) sendWord(2'd0, 32'hC0 + 32'(i));
      chk("mid_partial", outKey[223:192], 32'hC6);
      #2 inRstN = 1'b0;
      #1;
      chk("mid_rst_key", outKey, '0);
      chk("mid_rst_ready", outReady, 1'b1);
      chk("mid_rst_err", outErr, 1'b0);
      modelReset();
      @(negedge inClk);
      inRstN = 1'b1;
      @(posedge inClk);
      #1;
      for (int i = 0; i < 4; i++) sendWord(2'd1, 32'hD0 + 32'(i));
      for (int i = 0; i < 16; i++) sendWord(2'd2, 32'hE0 + 32'(i));
      for (int i = 0; i < 15; i++) sendWord(2'd0, 32'hF0 + 32'(i));
      chk("mid_no_launch", {outKeyWr, outReady}, 2'b01);
      sendWord(2'd0, 32'hFF);
      chk("mid_launch", {outKeyWr, outReady}, 2'b10);
      checkRegs("mid");
      inRstN = 1'b0;
      #1;
      chk("launch_rst_wr", {outKeyWr, outTweakWr, outBlockWr, outReady}, 4'b0001);
      @(negedge inClk);
      inRstN = 1'b1;
      idle(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
